// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: next-PC source encoding
// and default reset/exception vectors.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_BR,
        SRC_JMP,
        SRC_RAS,
        SRC_SEQ
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_gen_unit_ras.sv
// Circular return-address stack: top pointer plus saturating occupancy count.
// A full push silently overwrites the oldest entry.
module ras_stack #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] addr_i,
    output logic          empty_o,
    output logic [DW-1:0] top_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    // Simultaneous push+pop (call and ret together) rewrites the top in place;
    // on an empty stack it degenerates to an ordinary push.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push_i && pop_i && cnt_q != '0) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            ptr_d  = ptr_q + PW'(1);
            wr_idx = ptr_q + PW'(1);
            wr_en  = 1'b1;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                mem_q[wr_idx] <= addr_i;
            end
        end
    end

    assign empty_o = (cnt_q == '0);
    assign top_o   = empty_o ? '0 : mem_q[ptr_q];

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage fetch-address generator: PC register with prioritised next-PC
// selection, EPC capture/restore and return-address prediction.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int                   data_size    = 32,
    parameter logic [data_size-1:0] RESET_VECTOR = data_size'(DEF_RESET_VECTOR),
    parameter logic [data_size-1:0] EXC_VECTOR   = data_size'(DEF_EXC_VECTOR),
    parameter int                   INC          = 4,
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EN,
    input  logic                 exc_req,
    input  logic [data_size-1:0] exc_pc,
    input  logic                 eret,
    input  logic                 br_redirect,
    input  logic [data_size-1:0] br_target,
    input  logic                 jump,
    input  logic [data_size-1:0] jump_target,
    input  logic                 call,
    input  logic [data_size-1:0] call_ret_addr,
    input  logic                 ret,
    output logic [data_size-1:0] PC_out,
    output logic [data_size-1:0] PC_plus,
    output logic [data_size-1:0] epc_out,
    output logic                 ras_empty,
    output logic [data_size-1:0] ras_top
);

    logic [data_size-1:0] pc_q, pc_d;
    logic [data_size-1:0] epc_q, epc_d;
    pc_src_e              src;
    logic                 ras_upd;

    assign PC_plus = pc_q + data_size'(INC);

    always_comb begin
        src = SRC_SEQ;
        if (exc_req) begin
            src = SRC_EXC;
        end else if (eret) begin
            src = SRC_ERET;
        end else if (br_redirect) begin
            src = SRC_BR;
        end else if (jump) begin
            src = SRC_JMP;
        end else if (ret && !ras_empty) begin
            src = SRC_RAS;
        end
    end

    // Exceptions bypass the stall; every other source waits for EN to drop.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (src == SRC_EXC) begin
            pc_d  = EXC_VECTOR;
            epc_d = exc_pc;
        end else if (!EN) begin
            unique case (src)
                SRC_ERET: pc_d = epc_q;
                SRC_BR:   pc_d = br_target;
                SRC_JMP:  pc_d = jump_target;
                SRC_RAS:  pc_d = ras_top;
                default:  pc_d = PC_plus;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    // A call/ret alongside an exception or branch redirect is on the wrong path.
    assign ras_upd = !EN && !exc_req && !br_redirect;

    ras_stack #(
        .DW    (data_size),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_ni  (reset),
        .push_i  (ras_upd && call),
        .pop_i   (ras_upd && ret),
        .addr_i  (call_ret_addr),
        .empty_o (ras_empty),
        .top_o   (ras_top)
    );

    assign PC_out  = pc_q;
    assign epc_out = epc_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios plus random traffic,
// checked against a queue-based reference model of PC, EPC and the RAS.
module tb_pc_gen_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] EV    = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        EN = 1'b0, exc_req = 1'b0, eret = 1'b0, br_redirect = 1'b0;
    logic        jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] exc_pc = '0, br_target = '0, jump_target = '0, call_ret_addr = '0;
    logic [31:0] PC_out, PC_plus, epc_out, ras_top;
    logic        ras_empty;

    pc_gen_unit dut (
        .clk           (clk),
        .reset         (reset),
        .EN            (EN),
        .exc_req       (exc_req),
        .exc_pc        (exc_pc),
        .eret          (eret),
        .br_redirect   (br_redirect),
        .br_target     (br_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .call_ret_addr (call_ret_addr),
        .ret           (ret),
        .PC_out        (PC_out),
        .PC_plus       (PC_plus),
        .epc_out       (epc_out),
        .ras_empty     (ras_empty),
        .ras_top       (ras_top)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, en, exc, eret, br, jmp, call, ret;
        logic [31:0] epc_in, brt, jt, cra;
    } stim_t;

    typedef struct {
        logic [31:0] pc, plus, epc, top;
        logic        empty;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_pc = RV;
    logic [31:0] m_epc = '0;
    logic [31:0] m_ras[$];
    logic        prev_rst_n = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.en = 1'b0; s.exc = 1'b0; s.eret = 1'b0;
        s.br = 1'b0; s.jmp = 1'b0; s.call = 1'b0; s.ret = 1'b0;
        s.epc_in = '0; s.brt = '0; s.jt = '0; s.cra = '0;
        return s;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.plus  = m_pc + 32'd4;
        e.epc   = m_epc;
        e.empty = (m_ras.size() == 0);
        e.top   = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
        return e;
    endfunction

    // Drive one cycle of stimulus and record what the DUT must show after the edge.
    task automatic step(input stim_t s);
        logic [31:0] nxt;
        @(negedge clk);
        reset = s.rst_n; EN = s.en; exc_req = s.exc; exc_pc = s.epc_in;
        eret = s.eret; br_redirect = s.br; br_target = s.brt;
        jump = s.jmp; jump_target = s.jt; call = s.call;
        call_ret_addr = s.cra; ret = s.ret;
        if (!s.rst_n) begin
            m_pc = RV; m_epc = '0; m_ras.delete();
            if (prev_rst_n) begin
                #1;
                chk("async_rst_pc", PC_out, RV);
                chk("async_rst_empty", {31'b0, ras_empty}, 32'd1);
                chk("async_rst_epc", epc_out, 32'h0);
            end
        end else begin
            nxt = m_pc;
            if (s.exc) nxt = EV;
            else if (!s.en) begin
                if (s.eret) nxt = m_epc;
                else if (s.br) nxt = s.brt;
                else if (s.jmp) nxt = s.jt;
                else if (s.ret && m_ras.size() > 0) nxt = m_ras[m_ras.size()-1];
                else nxt = m_pc + 32'd4;
            end
            if (s.exc) m_epc = s.epc_in;
            if (!s.en && !s.exc && !s.br) begin
                if (s.call && s.ret && m_ras.size() > 0) begin
                    m_ras[m_ras.size()-1] = s.cra;
                end else if (s.call) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(s.cra);
                end else if (s.ret && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            m_pc = nxt;
        end
        prev_rst_n = s.rst_n;
        exp_q.push_back(snapshot());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out", PC_out, e.pc);
                chk("pc_plus", PC_plus, e.plus);
                chk("epc_out", epc_out, e.epc);
                chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
                chk("ras_top", ras_top, e.top);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        #1;
        chk("init_pc", PC_out, RV);
        chk("init_empty", {31'b0, ras_empty}, 32'd1);

        s = idle(); s.rst_n = 1'b0;
        repeat (2) step(s);
        repeat (3) step(idle());

        // Mid-run reset from PC 0x40
        s = idle(); s.jmp = 1'b1; s.jt = 32'h40; step(s);
        s = idle(); s.rst_n = 1'b0; step(s); step(s);
        repeat (3) step(idle());

        // Stall at 0x10
        s = idle(); s.jmp = 1'b1; s.jt = 32'h10; step(s);
        s = idle(); s.en = 1'b1; s.call = 1'b1; s.cra = 32'h77; repeat (3) step(s);
        step(idle());

        // Priority: exception under stall beats branch and jump, then eret
        s = idle(); s.en = 1'b1; s.exc = 1'b1; s.epc_in = 32'h24;
        s.br = 1'b1; s.brt = 32'h500; s.jmp = 1'b1; s.jt = 32'h600; s.eret = 1'b1;
        step(s);
        s = idle(); s.eret = 1'b1; s.br = 1'b1; s.brt = 32'h900; step(s);
        step(idle());

        // RAS: three calls, four returns
        for (int i = 1; i <= 3; i++) begin
            s = idle(); s.jmp = 1'b1; s.jt = 32'h2000 + 32'(i * 16);
            s.call = 1'b1; s.cra = 32'(i * 32'h100); step(s);
        end
        s = idle(); s.ret = 1'b1; repeat (4) step(s);

        // RAS overflow: five pushes, then drain
        for (int i = 1; i <= 5; i++) begin
            s = idle(); s.call = 1'b1; s.cra = 32'(i); step(s);
        end
        s = idle(); s.ret = 1'b1; repeat (5) step(s);

        // Wrap-around and call+ret replacement
        s = idle(); s.jmp = 1'b1; s.jt = 32'hFFFF_FFFC; step(s);
        step(idle());
        s = idle(); s.call = 1'b1; s.cra = 32'hAAA; step(s);
        s = idle(); s.call = 1'b1; s.ret = 1'b1; s.cra = 32'hBBB; step(s);
        s = idle(); s.ret = 1'b1; step(s); step(s);
        s = idle(); s.call = 1'b1; s.ret = 1'b1; s.cra = 32'hCCC; step(s);
        s = idle(); s.call = 1'b1; s.br = 1'b1; s.brt = 32'h300; s.cra = 32'hDDD; step(s);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.rst_n  = ($urandom_range(0, 199) != 0);
            s.en     = ($urandom_range(0, 3) == 0);
            s.exc    = ($urandom_range(0, 15) == 0);
            s.eret   = ($urandom_range(0, 9) == 0);
            s.br     = ($urandom_range(0, 7) == 0);
            s.jmp    = ($urandom_range(0, 5) == 0);
            s.call   = ($urandom_range(0, 3) == 0);
            s.ret    = ($urandom_range(0, 3) == 0);
            s.epc_in = $urandom & 32'hFFFF_FFFC;
            s.brt    = $urandom & 32'hFFFF_FFFC;
            s.jt     = $urandom & 32'hFFFF_FFFC;
            s.cra    = $urandom & 32'hFFFF_FFFC;
            step(s);
        end

        step(idle());
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
